// File: rtl/dec_pkg.sv
// Shared encodings for the multi-cycle control decoder: opcodes, FSM states
// and the packed bundle of datapath control strobes.
package dec_pkg;

  // Defined opcodes are contiguous from 0 so "known" is a single magnitude test.
  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_BNE   = 4'd2,
    OP_BEQ   = 4'd3,
    OP_ADD   = 4'd4,
    OP_SUB   = 4'd5,
    OP_ADDI  = 4'd6,
    OP_JMP   = 4'd7,
    OP_NOP   = 4'd8,
    OP_HALT  = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    MEM     = 2'd2,
    HALT    = 2'd3
  } state_e;

  typedef struct packed {
    logic load_reg;
    logic load_pc;
    logic load_ir;
    logic alu_reg;
    logic alu_add;
    logic alu_sub;
    logic inc_pc;
    logic we;
    logic imm;
    logic mem_req;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/dec_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles and flags the cycle
// in which the count reaches TMO without an acknowledge.
module dec_wait_timer #(
  parameter int TMO = 15
) (
  input  logic clock,
  input  logic n_reset,
  input  logic req,
  input  logic ack,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt;

  // cnt holds the waits already seen, so this cycle is wait number cnt+1.
  assign expired = req && !ack && (cnt == 8'(TMO - 1));

  // NOTE: state registers use non-blocking assignments and reset
  // asynchronously, so every flop sees the same pre-edge values.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (clear || ack || !req) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mc_decoder.sv
// Multi-cycle instruction decoder: FETCH/EXECUTE/MEM/HALT sequencer driving
// datapath strobes, with memory timeout, sticky error and retire counter.
module mc_decoder
  import dec_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16,
  parameter int TMO   = 15
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  input  logic             mem_ack,
  input  logic             run,
  output logic             load_REG,
  output logic             load_PC,
  output logic             load_IR,
  output logic             ALU_REG,
  output logic             ALU_add,
  output logic             ALU_sub,
  output logic             INC_PC,
  output logic             WE,
  output logic             IMM,
  output logic             mem_req,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_e  state, next_state;
  ctrl_t   ctrl, ctrl_out;
  opcode_e opc;
  logic    op_known;
  logic    set_err;
  logic    expired;
  logic    retire;

  assign op_known = (op <= OP_W'(OP_HALT));
  assign opc      = opcode_e'(op[3:0]);

  dec_wait_timer #(.TMO(TMO)) u_wait_timer (
    .clock   (clock),
    .n_reset (n_reset),
    .req     (ctrl.mem_req),
    .ack     (mem_ack),
    .clear   (next_state != state),
    .expired (expired)
  );

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ctrl       = '0;
    next_state = state;
    set_err    = 1'b0;
    case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ack) begin
          ctrl.load_ir = 1'b1;
          next_state   = EXECUTE;
        end else if (expired) begin
          set_err    = 1'b1;
          next_state = HALT;
        end
      end
      EXECUTE: begin
        if (!op_known) begin
          set_err    = 1'b1;
          next_state = HALT;
        end else begin
          case (opc)
            OP_ADD, OP_SUB, OP_ADDI: begin
              ctrl.load_reg = 1'b1;
              ctrl.alu_reg  = 1'b1;
              ctrl.alu_add  = (opc != OP_SUB);
              ctrl.alu_sub  = (opc == OP_SUB);
              ctrl.imm      = (opc == OP_ADDI);
              ctrl.load_pc  = 1'b1;
              ctrl.inc_pc   = 1'b1;
              next_state    = FETCH;
            end
            OP_NOP: begin
              ctrl.load_pc = 1'b1;
              ctrl.inc_pc  = 1'b1;
              next_state   = FETCH;
            end
            OP_BNE: begin
              ctrl.load_pc = 1'b1;
              ctrl.inc_pc  = z_flag;
              next_state   = FETCH;
            end
            OP_BEQ: begin
              ctrl.load_pc = 1'b1;
              ctrl.inc_pc  = !z_flag;
              next_state   = FETCH;
            end
            OP_JMP: begin
              ctrl.load_pc = 1'b1;
              next_state   = FETCH;
            end
            OP_LOAD, OP_STORE: next_state = MEM;
            OP_HALT:           next_state = HALT;
            default: begin
              set_err    = 1'b1;
              next_state = HALT;
            end
          endcase
        end
      end
      MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.we      = (opc == OP_STORE);
        if (mem_ack) begin
          ctrl.load_reg = (opc == OP_LOAD);
          ctrl.load_pc  = 1'b1;
          ctrl.inc_pc   = 1'b1;
          next_state    = FETCH;
        end else if (expired) begin
          set_err    = 1'b1;
          next_state = HALT;
        end
      end
      HALT: begin
        ctrl.halted = 1'b1;
        if (run) begin
          ctrl.load_pc = 1'b1;
          ctrl.inc_pc  = 1'b1;
          next_state   = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  // Strobes are forced low during reset so a stale decode never reaches memory.
  assign ctrl_out = n_reset ? ctrl : '0;

  assign load_REG = ctrl_out.load_reg;
  assign load_PC  = ctrl_out.load_pc;
  assign load_IR  = ctrl_out.load_ir;
  assign ALU_REG  = ctrl_out.alu_reg;
  assign ALU_add  = ctrl_out.alu_add;
  assign ALU_sub  = ctrl_out.alu_sub;
  assign INC_PC   = ctrl_out.inc_pc;
  assign WE       = ctrl_out.we;
  assign IMM      = ctrl_out.imm;
  assign mem_req  = ctrl_out.mem_req;
  assign halted   = ctrl_out.halted;

  assign retire = ((state == EXECUTE) || (state == MEM)) && (next_state == FETCH);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state       <= FETCH;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (set_err) err <= 1'b1;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_decoder.sv
// Randomized self-checking bench for mc_decoder using an instruction-level
// reference model of expected per-cycle strobes, retire count and error flag.
module tb_mc_decoder;
  import dec_pkg::*;

  localparam int OP_W  = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  localparam logic [10:0] M_LREG = 11'h400;
  localparam logic [10:0] M_LPC  = 11'h200;
  localparam logic [10:0] M_LIR  = 11'h100;
  localparam logic [10:0] M_AREG = 11'h080;
  localparam logic [10:0] M_ADD  = 11'h040;
  localparam logic [10:0] M_SUB  = 11'h020;
  localparam logic [10:0] M_INC  = 11'h010;
  localparam logic [10:0] M_WE   = 11'h008;
  localparam logic [10:0] M_IMM  = 11'h004;
  localparam logic [10:0] M_MREQ = 11'h002;
  localparam logic [10:0] M_HALT = 11'h001;

  logic             clock = 1'b0;
  logic             n_reset;
  logic [OP_W-1:0]  op;
  logic             z_flag, mem_ack, run;
  logic             load_REG, load_PC, load_IR, ALU_REG, ALU_add, ALU_sub;
  logic             INC_PC, WE, IMM, mem_req, halted, err;
  logic [CNT_W-1:0] instr_count;
  logic [10:0]      obs;

  int errors = 0;
  int checks = 0;
  int model_count = 0;
  bit model_err = 1'b0;

  mc_decoder #(.OP_W(OP_W), .CNT_W(CNT_W), .TMO(TMO)) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .op          (op),
    .z_flag      (z_flag),
    .mem_ack     (mem_ack),
    .run         (run),
    .load_REG    (load_REG),
    .load_PC     (load_PC),
    .load_IR     (load_IR),
    .ALU_REG     (ALU_REG),
    .ALU_add     (ALU_add),
    .ALU_sub     (ALU_sub),
    .INC_PC      (INC_PC),
    .WE          (WE),
    .IMM         (IMM),
    .mem_req     (mem_req),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  assign obs = {load_REG, load_PC, load_IR, ALU_REG, ALU_add, ALU_sub,
                INC_PC, WE, IMM, mem_req, halted};

  // Strobes expected in the EXECUTE cycle, straight from the instruction table.
  function automatic logic [10:0] exec_vec(input logic [3:0] o, input logic z);
    case (o)
      OP_ADD:  return M_LREG | M_AREG | M_ADD | M_LPC | M_INC;
      OP_SUB:  return M_LREG | M_AREG | M_SUB | M_LPC | M_INC;
      OP_ADDI: return M_LREG | M_AREG | M_ADD | M_IMM | M_LPC | M_INC;
      OP_NOP:  return M_LPC | M_INC;
      OP_BNE:  return M_LPC | (z ? M_INC : 11'h000);
      OP_BEQ:  return M_LPC | (z ? 11'h000 : M_INC);
      OP_JMP:  return M_LPC;
      default: return 11'h000;
    endcase
  endfunction

  // Called at a negedge with inputs already applied; compares mid-cycle and
  // returns at the next negedge, one rising edge later.
  task automatic step(input logic [10:0] exp, input string name, input string phase);
    #1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: strobes=%b required=%b", name, phase, obs, exp);
    end
    @(negedge clock);
  endtask

  task automatic check_status(input string name);
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = CNT_W'(model_count % (1 << CNT_W));
    #1;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s/count: instr_count=%0d required=%0d", name, instr_count, exp_cnt);
    end
    checks++;
    if (err !== model_err) begin
      errors++;
      $display("FAIL %s/err: err=%b required=%b", name, err, model_err);
    end
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    mem_ack = 1'b0;
    run     = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_reset     = 1'b1;
    model_count = 0;
    model_err   = 1'b0;
  endtask

  // One complete instruction: fetch with fd wait cycles, execute, then either
  // a memory phase with md waits or a halt phase of hd idle cycles before run.
  task automatic do_instr(input logic [3:0] o, input logic z, input int fd,
                          input int md, input int hd, input string name);
    logic [10:0] we_m;
    op = OP_W'($urandom);
    for (int i = 0; i < fd; i++) begin
      mem_ack = 1'b0;
      run     = 1'($urandom);
      step(M_MREQ, name, "fetch_wait");
    end
    mem_ack = 1'b1;
    run     = 1'($urandom);
    step(M_MREQ | M_LIR, name, "fetch_ack");
    op      = o;
    z_flag  = z;
    mem_ack = 1'($urandom);
    run     = 1'($urandom);
    step(exec_vec(o, z), name, "execute");
    if (o == OP_LOAD || o == OP_STORE) begin
      we_m = (o == OP_STORE) ? M_WE : 11'h000;
      for (int i = 0; i < md; i++) begin
        mem_ack = 1'b0;
        run     = 1'($urandom);
        z_flag  = 1'($urandom);
        step(M_MREQ | we_m, name, "mem_wait");
      end
      mem_ack = 1'b1;
      step(M_MREQ | we_m | M_LPC | M_INC | ((o == OP_LOAD) ? M_LREG : 11'h000),
           name, "mem_ack");
      model_count++;
    end else if (o >= OP_HALT) begin
      if (o != OP_HALT) model_err = 1'b1;
      for (int i = 0; i < hd; i++) begin
        run     = 1'b0;
        mem_ack = 1'($urandom);
        step(M_HALT, name, "halt_idle");
      end
      run = 1'b1;
      step(M_HALT | M_LPC | M_INC, name, "halt_run");
    end else begin
      model_count++;
    end
    run     = 1'b0;
    mem_ack = 1'b0;
    check_status(name);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    op      = OP_ADD;
    z_flag  = 1'b1;
    mem_ack = 1'b1;
    run     = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (obs !== 11'h000) begin
      errors++;
      $display("FAIL reset/strobes: strobes=%b required=%b", obs, 11'h000);
    end
    check_status("reset");
    @(negedge clock);
    n_reset = 1'b1;
    mem_ack = 1'b0;
    run     = 1'b0;
    step(M_MREQ, "reset", "first_req");
    apply_reset();
  endtask

  task automatic test_alu();
    apply_reset();
    do_instr(OP_ADD, 1'b0, 0, 0, 0, "add");
    do_instr(OP_SUB, 1'b1, 1, 0, 0, "sub");
    do_instr(OP_ADDI, 1'b0, 2, 0, 0, "addi");
    do_instr(OP_NOP, 1'b1, 0, 0, 0, "nop");
  endtask

  task automatic test_branches();
    do_instr(OP_BNE, 1'b0, 0, 0, 0, "bne_z0");
    do_instr(OP_BNE, 1'b1, 0, 0, 0, "bne_z1");
    do_instr(OP_BEQ, 1'b0, 1, 0, 0, "beq_z0");
    do_instr(OP_BEQ, 1'b1, 1, 0, 0, "beq_z1");
    do_instr(OP_JMP, 1'($urandom), 0, 0, 0, "jmp");
  endtask

  task automatic test_memory();
    do_instr(OP_STORE, 1'b0, 0, 3, 0, "store_delay3");
    do_instr(OP_LOAD, 1'b1, 1, 3, 0, "load_delay3");
    do_instr(OP_STORE, 1'b1, 3, 0, 0, "store_fetch_ack_at_tmo");
    do_instr(OP_LOAD, 1'b0, 0, 0, 0, "load_no_wait");
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) do_instr(OP_NOP, 1'($urandom), 0, 0, 0, "wrap_nop");
    do_instr(OP_HALT, 1'b0, 0, 0, 2, "wrap_halt");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TMO; i++) begin
      mem_ack = 1'b0;
      step(M_MREQ, "timeout", "fetch_wait");
    end
    model_err = 1'b1;
    run = 1'b0;
    step(M_HALT, "timeout", "halted");
    check_status("timeout");
    run = 1'b1;
    step(M_HALT | M_LPC | M_INC, "timeout", "resume");
    run = 1'b0;
    check_status("timeout_resume");
    do_instr(OP_ADD, 1'b0, 0, 0, 0, "after_timeout");
  endtask

  task automatic test_undefined();
    apply_reset();
    do_instr(4'hC, 1'b0, 0, 0, 1, "undefined");
    do_instr(OP_NOP, 1'b0, 0, 0, 0, "after_undefined");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_instr(4'($urandom_range(0, 15)), 1'($urandom),
               int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)),
               int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    do_instr(OP_NOP, 1'b0, 0, 0, 0, "pre_reset_nop");
    op      = OP_STORE;
    mem_ack = 1'b1;
    step(M_MREQ | M_LIR, "mid_mem", "fetch_ack");
    mem_ack = 1'b0;
    step(11'h000, "mid_mem", "execute");
    step(M_MREQ | M_WE, "mid_mem", "mem_wait");
    #2;
    n_reset = 1'b0;
    model_count = 0;
    model_err   = 1'b0;
    #1;
    checks++;
    if (obs !== 11'h000) begin
      errors++;
      $display("FAIL mid_mem/in_reset: strobes=%b required=%b", obs, 11'h000);
    end
    check_status("mid_mem_reset");
    mem_ack = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (obs !== 11'h000) begin
      errors++;
      $display("FAIL mid_mem/held_reset: strobes=%b required=%b", obs, 11'h000);
    end
    @(negedge clock);
    n_reset = 1'b1;
    mem_ack = 1'b1;
    step(M_MREQ | M_LIR, "mid_mem", "refetch");
    op = OP_NOP;
    mem_ack = 1'b0;
    step(M_LPC | M_INC, "mid_mem", "nop_exec");
    model_count++;
    check_status("mid_mem_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_branches();
    test_memory();
    test_wrap();
    test_timeout();
    test_undefined();
    test_random();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_decoder.md
MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 SHALL have parameter OP_W, default 4: opcode width, minimum 4.
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL have parameter TMO, default 15: maximum mem_ack wait cycles, range 1 to 255.
REQ-004 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port op, input, OP_W bits: opcode from the IR.
REQ-007 SHALL have port z_flag, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port mem_ack, input, 1 bit: memory transfer complete.
REQ-009 SHALL have port run, input, 1 bit: resume from HALT.
REQ-010 SHALL have outputs load_REG, load_PC, load_IR, ALU_REG, ALU_add, ALU_sub, INC_PC, WE and IMM, 1 bit each, with the existing datapath meanings.
REQ-011 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-012 SHALL have port halted, output, 1 bit: decoder is in HALT.
REQ-013 SHALL have port err, output, 1 bit: sticky fault flag.
REQ-014 SHALL have port instr_count, output, CNT_W bits: retired-instruction count.

Function
REQ-015 SHALL implement the states FETCH, EXECUTE, MEM and HALT; all control outputs SHALL default to 0 in every state.
REQ-016 In FETCH: mem_req=1; when mem_ack=1, load_IR=1 and next state is EXECUTE; otherwise stay in FETCH.
REQ-017 In EXECUTE, ADD/SUB/ADDI: load_REG=1, ALU_REG=1, ALU_add or ALU_sub=1 (ADDI also IMM=1), load_PC=1, INC_PC=1; next state FETCH.
REQ-018 In EXECUTE, NOP: load_PC=1, INC_PC=1; next state FETCH.
REQ-019 In EXECUTE, BNE: load_PC=1; INC_PC=z_flag.
REQ-020 In EXECUTE, BEQ: load_PC=1; INC_PC=!z_flag.
REQ-021 In EXECUTE, JMP: load_PC=1, INC_PC=0.
REQ-022 In EXECUTE, LOAD/STORE: no outputs asserted; next state MEM.
REQ-023 In MEM: mem_req=1; for STORE, WE=1 while in MEM; when mem_ack=1, load_REG=1 (LOAD only), load_PC=1, INC_PC=1, next state FETCH.
REQ-024 In EXECUTE, HALT opcode: no outputs asserted; next state HALT.
REQ-025 In EXECUTE, an undefined opcode: err set; next state HALT.
REQ-026 In HALT: halted=1; when run=1, load_PC=1, INC_PC=1, next state FETCH; otherwise stay in HALT.
REQ-027 run SHALL be ignored outside HALT.
REQ-028 A wait counter SHALL count consecutive cycles with mem_req=1 and mem_ack=0, and SHALL clear on mem_ack=1 or on a state change.
REQ-029 When the wait counter reaches TMO, err SHALL be set and the next state SHALL be HALT, with no load asserted that cycle.
REQ-030 If mem_ack=1 in the same cycle the wait counter reaches TMO, the acknowledge SHALL win: normal transition, no err.
REQ-031 err SHALL be sticky and SHALL clear only on reset; run SHALL resume from HALT even with err=1.
REQ-032 instr_count SHALL increment by 1 on each transition into FETCH from EXECUTE or MEM.
REQ-033 instr_count SHALL wrap modulo 2^CNT_W.
REQ-034 A transition from HALT into FETCH SHALL NOT increment instr_count.
REQ-035 Opcode is sampled in EXECUTE and MEM; op SHALL be held stable by the IR until FETCH.

Reset
REQ-036 While n_reset=0: state=FETCH, err=0, instr_count=0, wait counter=0.
REQ-037 While n_reset=0, all control outputs and mem_req SHALL be 0 irrespective of state decode.
REQ-038 Reset asserted mid-MEM SHALL abandon the transfer: no WE or load_REG pulse after reset assertion.
REQ-039 The first mem_req SHALL assert in the first cycle after n_reset rises.

Structure
REQ-040 Opcode encodings (LOAD, STORE, BNE, BEQ, ADD, SUB, ADDI, JMP, NOP, HALT) and the state enum SHALL live in shared package dec_pkg.
REQ-041 The wait counter and TMO compare SHALL be sub-module dec_wait_timer.
REQ-042 The state register, next-state logic and output logic SHALL reside in mc_decoder.

Verification
REQ-043 Reset, then mem_ack=1 every cycle, ADD -> load_IR in cycle 1; load_REG, ALU_add, load_PC and INC_PC in cycle 2; instr_count=1.
REQ-044 BNE with z_flag=0 -> load_PC=1, INC_PC=0; BNE with z_flag=1 -> INC_PC=1.
REQ-045 STORE with mem_ack delayed 3 cycles -> WE=1 for 4 MEM cycles; load_PC and INC_PC only on the ack cycle.
REQ-046 TMO=4, mem_ack held 0 in FETCH -> HALT after 4 wait cycles; err=1, halted=1; run=1 -> FETCH, err stays 1.
REQ-047 CNT_W=4, 16 NOPs -> instr_count wraps to 0; HALT then run -> count unchanged.
REQ-048 Reset pulse in MEM during a STORE -> WE=0 immediately, state FETCH, instr_count=0.
